// File: rtl/spart_if.sv
// Access strobe bundle between the SPART driver (master) and the SPART (slave).
// iocs marks a one-cycle access. It is qualified by iorw and ioaddr in the same cycle.
// rda and tbr are level status flags that the SPART raises.
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// Programs the SPART baud divisor and echoes every received byte back to the transmitter.
// Reconfigures whenever br_cfg changes while the driver is idle.
module spart_driver (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  br_cfg,
    spart_if.master     bus,
    inout  wire  [7:0]  databus,
    output logic [7:0]  last_rx,
    output logic        rx_strobe,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        CFG_LO   = 3'd0,
        CFG_HI   = 3'd1,
        IDLE     = 3'd2,
        READ     = 3'd3,
        WAIT_TBR = 3'd4,
        WRITE    = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cfg_q;
    logic        cfg_valid;
    logic [1:0]  cfg_eff;
    logic [15:0] divisor;
    logic [7:0]  echo_buf;
    logic        iocs_c, iorw_c, drive_en;
    logic [1:0]  ioaddr_c;
    logic [7:0]  drive_data;

    // Until the first configuration has been captured, follow the live br_cfg.
    assign cfg_eff = cfg_valid ? cfg_q : br_cfg;

    always_comb begin
        divisor = 16'h28B1;
        case (cfg_eff)
            2'b00: divisor = 16'h28B1;
            2'b01: divisor = 16'h1458;
            2'b10: divisor = 16'h0A2C;
            2'b11: divisor = 16'h0516;
            default: divisor = 16'h28B1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CFG_LO;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CFG_LO:   state_nxt = CFG_HI;
            CFG_HI:   state_nxt = IDLE;
            IDLE: begin
                if (br_cfg != cfg_eff) state_nxt = CFG_LO;
                else if (bus.rda)      state_nxt = READ;
            end
            READ:     state_nxt = WAIT_TBR;
            WAIT_TBR: if (bus.tbr) state_nxt = WRITE;
            WRITE:    state_nxt = IDLE;
            default:  state_nxt = CFG_LO;
        endcase
    end

    // Outputs are gated by rst so an assertion mid-access drops the bus without waiting for a clock.
    always_comb begin
        iocs_c     = 1'b0;
        iorw_c     = 1'b1;
        ioaddr_c   = 2'b00;
        drive_en   = 1'b0;
        drive_data = 8'h00;
        if (rst) begin
            case (state)
                CFG_LO: begin
                    iocs_c     = 1'b1;
                    iorw_c     = 1'b0;
                    ioaddr_c   = 2'b10;
                    drive_en   = 1'b1;
                    drive_data = divisor[7:0];
                end
                CFG_HI: begin
                    iocs_c     = 1'b1;
                    iorw_c     = 1'b0;
                    ioaddr_c   = 2'b11;
                    drive_en   = 1'b1;
                    drive_data = divisor[15:8];
                end
                READ: begin
                    iocs_c     = 1'b1;
                end
                WRITE: begin
                    iocs_c     = 1'b1;
                    iorw_c     = 1'b0;
                    drive_en   = 1'b1;
                    drive_data = echo_buf;
                end
                default: ;
            endcase
        end
    end

    // cfg_q is refreshed on every entry to CFG_LO, so both divisor bytes come from one snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q     <= 2'b00;
            cfg_valid <= 1'b0;
        end else if ((state == CFG_LO && !cfg_valid) ||
                     (state == IDLE && br_cfg != cfg_eff)) begin
            cfg_q     <= br_cfg;
            cfg_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_buf  <= 8'h00;
            last_rx   <= 8'h00;
            rx_strobe <= 1'b0;
        end else begin
            rx_strobe <= (state == READ);
            if (state == READ) begin
                echo_buf <= databus;
                last_rx  <= databus;
            end
        end
    end

    assign bus.iocs   = iocs_c;
    assign bus.iorw   = iorw_c;
    assign bus.ioaddr = ioaddr_c;
    assign databus    = drive_en ? drive_data : 8'hzz;
    assign dbg_state  = state;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: configuration, echo path, reconfiguration priority and reset abort.
module tb_spart_driver;
  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  wire  [7:0] databus;
  logic [7:0] last_rx;
  logic       rx_strobe;
  logic [2:0] dbg_state;
  logic [7:0] rx_byte;
  int         n_checks;
  int         n_fail;

  localparam logic [2:0] S_CFG_LO = 3'd0, S_CFG_HI = 3'd1, S_IDLE = 3'd2,
                         S_READ = 3'd3, S_WAIT = 3'd4, S_WRITE = 3'd5;

  spart_if bus ();

  spart_driver dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .bus       (bus.master),
    .databus   (databus),
    .last_rx   (last_rx),
    .rx_strobe (rx_strobe),
    .dbg_state (dbg_state)
  );

  // SPART model: it returns rx_byte on a buffer read.
  assign databus = (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) ? rx_byte : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_cfg(input string tag, input logic [1:0] addr, input logic [7:0] data);
    check({tag, "_iocs"}, {15'd0, bus.iocs}, 16'd1);
    check({tag, "_iorw"}, {15'd0, bus.iorw}, 16'd0);
    check({tag, "_addr"}, {14'd0, bus.ioaddr}, {14'd0, addr});
    check({tag, "_data"}, {8'd0, databus}, {8'd0, data});
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_iocs"}, {15'd0, bus.iocs}, 16'd0);
    check({tag, "_iorw"}, {15'd0, bus.iorw}, 16'd1);
    check({tag, "_addr"}, {14'd0, bus.ioaddr}, 16'd0);
    check({tag, "_bus_z"}, {8'd0, databus}, {8'd0, 8'hzz});
  endtask

  task automatic check_write(input string tag, input logic [7:0] data);
    check({tag, "_state"}, {13'd0, dbg_state}, {13'd0, S_WRITE});
    check_cfg(tag, 2'b00, data);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    br_cfg   = 2'b01;
    rx_byte  = 8'h00;
    bus.rda  = 1'b0;
    bus.tbr  = 1'b0;

    // Reset state and the first configuration after release
    repeat (3) step();
    check_quiet("rst");
    check("rst_state", {13'd0, dbg_state}, {13'd0, S_CFG_LO});
    check("rst_last_rx", {8'd0, last_rx}, 16'h0000);
    check("rst_rx_strobe", {15'd0, rx_strobe}, 16'd0);
    rst = 1'b1;
    #1;
    check_cfg("cfg01_lo", 2'b10, 8'h58);
    step();
    check_cfg("cfg01_hi", 2'b11, 8'h14);
    step();
    check_quiet("cfg01_idle");
    step();
    check_quiet("idle_hold");

    // Echo with tbr already high: read, strobe, write three cycles after rda
    rx_byte = 8'h41; bus.rda = 1'b1; bus.tbr = 1'b1;
    step();
    check("e1_read_state", {13'd0, dbg_state}, {13'd0, S_READ});
    check("e1_read_iocs", {15'd0, bus.iocs}, 16'd1);
    check("e1_read_iorw", {15'd0, bus.iorw}, 16'd1);
    check("e1_read_addr", {14'd0, bus.ioaddr}, 16'd0);
    bus.rda = 1'b0;
    step();
    check("e1_wait_iocs", {15'd0, bus.iocs}, 16'd0);
    check("e1_rx_strobe", {15'd0, rx_strobe}, 16'd1);
    check("e1_last_rx", {8'd0, last_rx}, 16'h0041);
    step();
    check_write("e1_write", 8'h41);
    check("e1_strobe_done", {15'd0, rx_strobe}, 16'd0);
    step();
    check_quiet("e1_idle");
    check("e1_idle_state", {13'd0, dbg_state}, {13'd0, S_IDLE});

    // tbr held low for 100 cycles: no write until tbr rises
    rx_byte = 8'hA5; bus.rda = 1'b1; bus.tbr = 1'b0;
    step();
    check("e2_read_state", {13'd0, dbg_state}, {13'd0, S_READ});
    bus.rda = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      check("e2_hold_iocs", {15'd0, bus.iocs}, 16'd0);
    end
    check("e2_hold_state", {13'd0, dbg_state}, {13'd0, S_WAIT});
    check("e2_last_rx", {8'd0, last_rx}, 16'h00A5);
    bus.tbr = 1'b1;
    step();
    check_write("e2_write", 8'hA5);
    step();
    check_quiet("e2_idle");

    // br_cfg change during WAIT_TBR is deferred until the echo finishes
    rx_byte = 8'h3C; bus.rda = 1'b1; bus.tbr = 1'b0;
    step();
    bus.rda = 1'b0;
    step();
    br_cfg = 2'b11;
    step();
    check("e3_wait_state", {13'd0, dbg_state}, {13'd0, S_WAIT});
    bus.tbr = 1'b1;
    step();
    check_write("e3_write", 8'h3C);
    step();
    check("e3_idle_state", {13'd0, dbg_state}, {13'd0, S_IDLE});
    step();
    check_cfg("cfg11_lo", 2'b10, 8'h16);
    step();
    check_cfg("cfg11_hi", 2'b11, 8'h05);
    step();
    check_quiet("cfg11_idle");

    // br_cfg change and rda in the same IDLE cycle: reconfigure first
    br_cfg = 2'b10; rx_byte = 8'h7E; bus.rda = 1'b1; bus.tbr = 1'b1;
    step();
    check_cfg("cfg10_lo", 2'b10, 8'h2C);
    step();
    check_cfg("cfg10_hi", 2'b11, 8'h0A);
    step();
    check("e4_idle_state", {13'd0, dbg_state}, {13'd0, S_IDLE});
    step();
    check("e4_read_state", {13'd0, dbg_state}, {13'd0, S_READ});
    bus.rda = 1'b0;
    step();
    check("e4_last_rx", {8'd0, last_rx}, 16'h007E);
    step();
    check_write("e4_write", 8'h7E);
    step();
    check_quiet("e4_idle");

    // Reset asserted mid-WRITE drops the access immediately
    rx_byte = 8'h99; bus.rda = 1'b1; bus.tbr = 1'b1;
    step();
    bus.rda = 1'b0;
    step();
    step();
    check_write("e5_write", 8'h99);
    rst = 1'b0;
    #1;
    check_quiet("e5_abort");
    check("e5_abort_state", {13'd0, dbg_state}, {13'd0, S_CFG_LO});
    check("e5_abort_last_rx", {8'd0, last_rx}, 16'h0000);
    step();
    step();
    rst = 1'b1;
    #1;
    check_cfg("cfg10b_lo", 2'b10, 8'h2C);
    step();
    check_cfg("cfg10b_hi", 2'b11, 8'h0A);
    step();
    check_quiet("cfg10b_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
